// File: rtl/mvu_pe_acc_if.sv
// Beat/result bus between the SIMD multiplier lanes and the per-PE accumulator.
// The master drives the product beats; the slave returns the completed dot product.
interface mvu_pe_acc_if #(
  parameter int SIMD = 2,
  parameter int TO   = 8,
  parameter int TA   = 16
) ();

  logic                 in_v;
  logic [SIMD*TO-1:0]   in_prod;
  logic                 out_v;
  logic [TA-1:0]        out;

  modport master (
    output in_v,
    output in_prod,
    input  out_v,
    input  out
  );

  modport slave (
    input  in_v,
    input  in_prod,
    output out_v,
    output out
  );

endinterface

// File: rtl/mvu_pe_acc.sv
// Per-PE reduction: registered adder tree over the SIMD lanes, then a synapse-fold
// accumulator that emits one TA-bit dot product every SF valid beats.
module mvu_pe_acc #(
  parameter int SIMD = 2,
  parameter int TO   = 8,
  parameter int TA   = 16,
  parameter int SF   = 4
) (
  input  logic         clk,
  input  logic         rst,
  mvu_pe_acc_if.slave  bus
);

  localparam int P  = 1 << $clog2(SIMD);
  localparam int CW = (SF > 1) ? $clog2(SF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SF - 1);

  logic [TA-1:0] tree [2*P-1];
  logic [TA-1:0] sum_q;
  logic          sum_v;
  logic [TA-1:0] acc;
  logic [TA-1:0] acc_next;
  logic [CW-1:0] cnt;
  logic [TA-1:0] out_q;
  logic          out_v_q;

  // Heap-ordered pairwise tree: leaves at P-1.., root at 0. Lanes are masked
  // by in_v so idle (possibly undriven) products never reach the registers.
  always_comb begin
    for (int n = 0; n < 2*P-1; n++) begin
      tree[n] = '0;
    end
    for (int i = 0; i < SIMD; i++) begin
      tree[P-1+i] = bus.in_v ? TA'(bus.in_prod[i*TO +: TO]) : '0;
    end
    for (int k = P-2; k >= 0; k--) begin
      tree[k] = tree[2*k+1] + tree[2*k+2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_q <= '0;
      sum_v <= 1'b0;
    end else begin
      sum_q <= tree[0];
      sum_v <= bus.in_v;
    end
  end

  // Beat 0 of a row loads instead of adding, so the previous row never leaks in.
  always_comb begin
    acc_next = (cnt == '0) ? sum_q : acc + sum_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc     <= '0;
      cnt     <= '0;
      out_q   <= '0;
      out_v_q <= 1'b0;
    end else begin
      out_v_q <= 1'b0;
      if (sum_v) begin
        acc <= acc_next;
        if (cnt == CNT_LAST) begin
          cnt     <= '0;
          out_q   <= acc_next;
          out_v_q <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.out   = out_q;
  assign bus.out_v = out_v_q;

endmodule

// File: tb/tb_mvu_pe_acc.sv
// Scoreboard bench for mvu_pe_acc: three instances (base, narrow-accumulator wrap,
// SF=1) share one clock/reset; expected results are queued with their strobe cycle.
module tb_mvu_pe_acc;

  typedef struct {
    logic [15:0] val;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  exp_t qA[$];
  exp_t qW[$];
  exp_t qS[$];
  exp_t eA, eW, eS;

  mvu_pe_acc_if #(.SIMD(2), .TO(8), .TA(16)) ifA ();
  mvu_pe_acc_if #(.SIMD(2), .TO(8), .TA(8))  ifW ();
  mvu_pe_acc_if #(.SIMD(2), .TO(8), .TA(16)) ifS ();

  mvu_pe_acc #(.SIMD(2), .TO(8), .TA(16), .SF(4)) uA (.clk(clk), .rst(rst), .bus(ifA));
  mvu_pe_acc #(.SIMD(2), .TO(8), .TA(8),  .SF(4)) uW (.clk(clk), .rst(rst), .bus(ifW));
  mvu_pe_acc #(.SIMD(2), .TO(8), .TA(16), .SF(1)) uS (.clk(clk), .rst(rst), .bus(ifS));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv)
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    else
      passes++;
  endtask

  task automatic flagFail(input string name);
    checks++;
    $display("[TB] FAIL %s: got strobe, expected none (cycle %0d)", name, cyc);
  endtask

  // Monitors: each strobe must match the oldest queued result, value and cycle.
  always @(negedge clk) begin
    if (ifA.out_v !== 1'b0) begin
      if (qA.size() == 0) flagFail("strobeA");
      else begin
        eA = qA.pop_front();
        checkOutput("resultA", ifA.out, eA.val);
        checkOutput("cycleA", 16'(cyc), 16'(eA.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (ifW.out_v !== 1'b0) begin
      if (qW.size() == 0) flagFail("strobeW");
      else begin
        eW = qW.pop_front();
        checkOutput("resultW", {8'h00, ifW.out}, eW.val);
        checkOutput("cycleW", 16'(cyc), 16'(eW.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (ifS.out_v !== 1'b0) begin
      if (qS.size() == 0) flagFail("strobeS");
      else begin
        eS = qS.pop_front();
        checkOutput("resultS", ifS.out, eS.val);
        checkOutput("cycleS", 16'(cyc), 16'(eS.cyc));
      end
    end
  end

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      ifA.in_v = 1'b0;
      ifW.in_v = 1'b0;
      ifS.in_v = 1'b0;
    end
  endtask

  // One beat to instance sel (0=A, 1=W, 2=S); a last beat queues its hand-computed result.
  task automatic applyStimulus(input int sel, input logic [7:0] l0, input logic [7:0] l1,
                               input bit last, input logic [15:0] expVal);
    exp_t e;
    @(negedge clk);
    ifA.in_v = 1'b0;
    ifW.in_v = 1'b0;
    ifS.in_v = 1'b0;
    e.val = expVal;
    e.cyc = cyc + 2;
    case (sel)
      0: begin ifA.in_v = 1'b1; ifA.in_prod = {l1, l0}; if (last) qA.push_back(e); end
      1: begin ifW.in_v = 1'b1; ifW.in_prod = {l1, l0}; if (last) qW.push_back(e); end
      default: begin ifS.in_v = 1'b1; ifS.in_prod = {l1, l0}; if (last) qS.push_back(e); end
    endcase
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_outA"},  ifA.out, 16'd0);
    checkOutput({tag, "_vA"},    16'(ifA.out_v), 16'd0);
    checkOutput({tag, "_outW"},  {8'h00, ifW.out}, 16'd0);
    checkOutput({tag, "_outS"},  ifS.out, 16'd0);
  endtask

  initial begin
    ifA.in_v = 1'b0; ifA.in_prod = '0;
    ifW.in_v = 1'b0; ifW.in_prod = '0;
    ifS.in_v = 1'b0; ifS.in_prod = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b1;
    idleCycles(2);

    $display("[TB] basic row");
    applyStimulus(0, 8'd1, 8'd2, 1'b0, 16'd0);
    applyStimulus(0, 8'd3, 8'd4, 1'b0, 16'd0);
    applyStimulus(0, 8'd5, 8'd6, 1'b0, 16'd0);
    applyStimulus(0, 8'd7, 8'd8, 1'b1, 16'd36);
    idleCycles(4);
    checkOutput("holdBasic", ifA.out, 16'd36);

    $display("[TB] back-to-back rows with gaps");
    for (int b = 0; b < 4; b++) applyStimulus(0, 8'd1, 8'd1, b == 3, 16'd8);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(0, 8'd255, 8'd255, b == 3, 16'd2040);
      if (b < 3) idleCycles(int'($urandom_range(0, 3)));
    end
    idleCycles(4);
    checkOutput("holdGap", ifA.out, 16'h07F8);

    $display("[TB] idle X then row");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ifA.in_v = 1'b0;
      ifA.in_prod = 'x;
    end
    checkOutput("idleXhold", ifA.out, 16'h07F8);
    applyStimulus(0, 8'd2, 8'd3, 1'b0, 16'd0);
    applyStimulus(0, 8'd4, 8'd5, 1'b0, 16'd0);
    applyStimulus(0, 8'd6, 8'd7, 1'b0, 16'd0);
    applyStimulus(0, 8'd8, 8'd9, 1'b1, 16'd44);
    idleCycles(4);
    checkOutput("holdAfterX", ifA.out, 16'd44);

    $display("[TB] wrap");
    for (int b = 0; b < 4; b++) applyStimulus(1, 8'd255, 8'd255, b == 3, 16'h00F8);
    idleCycles(4);
    checkOutput("holdWrap", {8'h00, ifW.out}, 16'h00F8);

    $display("[TB] SF=1");
    applyStimulus(2, 8'd10, 8'd20, 1'b1, 16'd30);
    applyStimulus(2, 8'd0, 8'd0, 1'b1, 16'd0);
    applyStimulus(2, 8'd255, 8'd1, 1'b1, 16'd256);
    idleCycles(4);
    checkOutput("holdSF1", ifS.out, 16'd256);

    $display("[TB] reset mid-row");
    applyStimulus(0, 8'd1, 8'd2, 1'b0, 16'd0);
    applyStimulus(0, 8'd3, 8'd4, 1'b0, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    ifA.in_v = 1'b1;
    ifA.in_prod = {8'd9, 8'd9};
    @(negedge clk);
    checkAllZero("midReset");
    rst = 1'b1;
    ifA.in_v = 1'b0;
    applyStimulus(0, 8'd1, 8'd1, 1'b0, 16'd0);
    applyStimulus(0, 8'd1, 8'd1, 1'b0, 16'd0);
    checkOutput("postResetOut", ifA.out, 16'd0);
    applyStimulus(0, 8'd1, 8'd1, 1'b0, 16'd0);
    applyStimulus(0, 8'd1, 8'd1, 1'b1, 16'd8);
    idleCycles(4);
    checkOutput("holdReset", ifA.out, 16'd8);

    idleCycles(10);
    checkOutput("drainA", 16'(qA.size()), 16'd0);
    checkOutput("drainW", 16'(qW.size()), 16'd0);
    checkOutput("drainS", 16'(qS.size()), 16'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
